// File: rtl/bsg_fsb_pkg.sv
// Shared types and helpers for the test node sequencer.
// State encoding and node index sizing.
package bsg_fsb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    RUN,
    GAP,
    DONE
  } bsg_test_seq_state_e;

  function automatic int node_idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_test_node_watchdog.sv
// Per-node cycle watchdog: saturating counter with clear/enable.
// expired_o is registered and is high on the last allowed cycle.
module bsg_test_node_watchdog #(
  parameter int width_p = 24
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [width_p-1:0] limit_i,
  output logic               expired_o
);

  logic [width_p-1:0] count_r;
  logic [width_p-1:0] count_n;
  logic               exp_n;

  // next count (saturating) and look-ahead compare against limit-1
  always_comb begin
    count_n = count_r;
    if (clr_i)
      count_n = '0;
    else if (en_i && !(&count_r))
      count_n = count_r + width_p'(1);
    exp_n = (limit_i != '0)
         && (count_n == limit_i - width_p'(1));
  end

  // counter and expired flag registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r   <= '0;
      expired_o <= 1'b0;
    end else if (clr_i || en_i) begin
      count_r   <= count_n;
      expired_o <= exp_n;
    end
  end

endmodule

// File: rtl/bsg_test_node_sequencer.sv
// Runs masked-in test node masters one at a time in index order,
// with a per-node watchdog and aggregate pass/fail reporting.
module bsg_test_node_sequencer
  import bsg_fsb_pkg::*;
#(
  parameter int num_nodes_p     = 4,
  parameter int timeout_width_p = 24,
  parameter int gap_cycles_p    = 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic [num_nodes_p-1:0]     node_mask_i,
  input  logic [timeout_width_p-1:0] timeout_i,
  input  logic [num_nodes_p-1:0]     node_done_i,
  input  logic [num_nodes_p-1:0]     node_error_i,
  output logic [num_nodes_p-1:0]     node_en_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       pass_o,
  output logic                       error_o,
  output logic                       timeout_o,
  output logic [node_idx_width(num_nodes_p)-1:0] fail_node_o
);

  localparam int iw_lp = node_idx_width(num_nodes_p);
  localparam logic [iw_lp-1:0] last_lp = iw_lp'(num_nodes_p - 1);
  localparam logic [3:0] gap_ld_lp = 4'(gap_cycles_p - 1);

  bsg_test_seq_state_e state_r, state_n;
  logic [iw_lp-1:0]           cur_r, cur_n;
  logic [3:0]                 gap_r, gap_n;
  logic [num_nodes_p-1:0]     mask_r, mask_n;
  logic [timeout_width_p-1:0] limit_r, limit_n;

  logic                   err_n, to_n, pass_n;
  logic [iw_lp-1:0]       fail_n;
  logic [num_nodes_p-1:0] en_n;
  logic                   busy_n, done_n;

  logic                   wd_clr, wd_en, wd_expired;
  logic [num_nodes_p-1:0] cur_oh, other_err;
  logic [iw_lp-1:0]       other_idx;

  assign wd_en = (state_r == RUN);

  bsg_test_node_watchdog #(
    .width_p(timeout_width_p)
  ) wd (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .limit_i  (limit_r),
    .expired_o(wd_expired)
  );

  // state, context and registered outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= IDLE;
      cur_r       <= '0;
      gap_r       <= '0;
      mask_r      <= '0;
      limit_r     <= '0;
      node_en_o   <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      error_o     <= 1'b0;
      timeout_o   <= 1'b0;
      fail_node_o <= '0;
    end else begin
      state_r     <= state_n;
      cur_r       <= cur_n;
      gap_r       <= gap_n;
      mask_r      <= mask_n;
      limit_r     <= limit_n;
      node_en_o   <= en_n;
      busy_o      <= busy_n;
      done_o      <= done_n;
      pass_o      <= pass_n;
      error_o     <= err_n;
      timeout_o   <= to_n;
      fail_node_o <= fail_n;
    end
  end

  // next state, node index and result flags
  always_comb begin
    state_n = state_r;
    cur_n   = cur_r;
    gap_n   = gap_r;
    mask_n  = mask_r;
    limit_n = limit_r;
    err_n   = error_o;
    to_n    = timeout_o;
    pass_n  = pass_o;
    fail_n  = fail_node_o;
    wd_clr  = 1'b0;

    cur_oh    = num_nodes_p'(1) << cur_r;
    other_err = '0;
    if (state_r == RUN)
      other_err = node_error_i & ~cur_oh;
    else if (state_r == GAP)
      other_err = node_error_i;
    other_idx = '0;
    for (int i = num_nodes_p - 1; i >= 0; i--)
      if (other_err[i]) other_idx = iw_lp'(i);

    unique case (state_r)
      IDLE, DONE: begin
        if (start_i) begin
          mask_n  = node_mask_i;
          limit_n = timeout_i;
          err_n   = 1'b0;
          to_n    = 1'b0;
          pass_n  = 1'b0;
          fail_n  = '0;
          cur_n   = '0;
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (mask_r[cur_r]) begin
          state_n = RUN;
          wd_clr  = 1'b1;
        end else if (cur_r == last_lp) begin
          state_n = DONE;
          pass_n  = 1'b1;
        end else begin
          cur_n = cur_r + iw_lp'(1);
        end
      end
      RUN: begin
        if (node_error_i[cur_r]) begin
          err_n   = 1'b1;
          fail_n  = cur_r;
          state_n = DONE;
        end else if (node_done_i[cur_r]) begin
          if (cur_r == last_lp) begin
            state_n = DONE;
            pass_n  = 1'b1;
          end else begin
            cur_n = cur_r + iw_lp'(1);
            if (gap_cycles_p == 0) begin
              state_n = SCAN;
            end else begin
              state_n = GAP;
              gap_n   = gap_ld_lp;
            end
          end
        end else if (wd_expired) begin
          to_n    = 1'b1;
          fail_n  = cur_r;
          state_n = DONE;
        end else if (|other_err) begin
          err_n   = 1'b1;
          fail_n  = other_idx;
          state_n = DONE;
        end
      end
      GAP: begin
        if (|other_err) begin
          err_n   = 1'b1;
          fail_n  = other_idx;
          state_n = DONE;
        end else if (gap_r == '0) begin
          state_n = SCAN;
        end else begin
          gap_n = gap_r - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // output values for the state being entered
  always_comb begin
    en_n = '0;
    if (state_n == RUN)
      en_n = num_nodes_p'(1) << cur_n;
    busy_n = (state_n == RUN) || (state_n == GAP);
    done_n = (state_n == DONE);
  end

endmodule
